regfile_write_ctrl: RTL and testbench
=====================================

# regfile_write_ctrl

Write-port controller for the 32 x 64-bit register file. After reset it clears registers 1..NUM_REGS-1 to zero, because the register array itself has no reset. It then shares the single register-file write port between two writeback requesters: A (ALU result) and B (load result). Arbitration is round-robin with valid/ready handshakes, and the register-file write signals are registered.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero
- DATA_WIDTH, 64, write data width
- ADDR_WIDTH, 6, register index width; must match the register file's write_register port

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- a_valid  in  1  requester A has a write pending
- a_addr  in  ADDR_WIDTH  requester A destination register
- a_data  in  DATA_WIDTH  requester A write data
- a_ready  out  1  requester A transfer accepted this cycle when a_valid=1
- b_valid  in  1  requester B has a write pending
- b_addr  in  ADDR_WIDTH  requester B destination register
- b_data  in  DATA_WIDTH  requester B write data
- b_ready  out  1  requester B transfer accepted this cycle when b_valid=1
- rf_reg_write  out  1  registered write enable to the register file
- rf_write_register  out  ADDR_WIDTH  registered write index
- rf_write_data  out  DATA_WIDTH  registered write data
- rf_src  out  1  registered source of the current write: 0=A or sweep, 1=B
- init_done  out  1  high once the clear sweep has issued its last write

## Operation
- States: INIT, RUN. Reset forces INIT, sweep counter cnt=1, priority pointer prio=A.
- INIT:
  - Each edge loads rf_reg_write=1, rf_write_register=cnt, rf_write_data=0, rf_src=0.
  - If cnt==NUM_REGS-1, the same edge sets state=RUN and init_done=1. Otherwise cnt increments.
  - a_ready=b_ready=0 throughout INIT.
- RUN ready logic (combinational, independent of the requester's own valid):
  - a_ready = (!b_valid || prio==A)
  - b_ready = (!a_valid || prio==B)
- Transfer: valid&&ready. At most one transfer per cycle.
- Priority: after a transfer from X, prio becomes not-X. With no transfer, prio holds.
- On the edge ending a transfer cycle, outputs load {write enable, addr, data, src} from the winner.
  - Write enable is 1 only when 0 < addr < NUM_REGS.
  - addr 0 and addr >= NUM_REGS complete the handshake but are dropped (rf_reg_write=0).
- No transfer in a RUN cycle: rf_reg_write loads 0; other outputs hold.
- Requesters hold valid, addr and data stable until ready; the block never buffers more than the single output register.
- Same destination from A and B in the same cycle: writes land in grant order, and the later write wins in the register file.

## Timing
- Reset values: rf_reg_write=0, rf_write_register=0, rf_write_data=0, rf_src=0, init_done=0, a_ready=0, b_ready=0.
- rst is asynchronous, so reset values appear immediately on assertion. It takes effect at any point, mid-sweep or mid-RUN, and pending requests are simply not accepted.
- Sweep: first edge after rst deasserts writes reg 1. Edge k writes reg k. Edge NUM_REGS-1 (31) writes the last register and raises init_done.
- Readies may assert in the cycle after edge 31.
- Latency: request accepted in cycle n gives rf write visible in cycle n+1 and committed to the register file at edge n+2.
- Throughput: one write per cycle. Both requesters continuously valid alternate strictly A,B,A,B.
- The first contended grant after reset goes to A.

## Test plan
- Reset, then idle for 40 cycles:
  - rf_reg_write=1 for exactly 31 cycles, indices 1..31 in order, data 0.
  - init_done rises with the reg-31 write.
  - a_ready=b_ready=0 throughout the sweep, then rf_reg_write=0.
- After init, a single A request (addr 5, data 0x0000_0000_DEAD_BEEF) for one cycle:
  - a_ready=1.
  - Next cycle rf_reg_write=1, rf_write_register=5, rf_write_data=0xDEADBEEF, rf_src=0.
  - Reading reg 5 afterwards returns 0xDEADBEEF.
- A and B both valid continuously (A: addr 1..4, B: addr 11..14, advancing on each accept):
  - Writes appear as 1,11,2,12,3,13,4,14 on consecutive cycles.
  - rf_src alternates 0,1.
- A addr 0 data 0x55, then B addr 40 data 0x66:
  - Both handshakes complete.
  - rf_reg_write stays 0; reg 0 still reads 0.
- B valid (addr 7, data 0x77) held from reset release:
  - b_ready=0 during the sweep, accepted in the first RUN cycle.
  - Reg 7 write appears the cycle after reg 31 write.
- Assert rst asynchronously mid-clock after sweep edge 10:
  - All outputs go to reset values immediately.
  - After release, the sweep restarts at reg 1 and takes a full 31 cycles.

Source files
------------

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: clears registers 1..NUM_REGS-1 after reset, then shares
// the single register-file write port between the ALU (A) and load (B)
// writeback requesters using a round-robin valid/ready arbiter.
module regfile_write_ctrl #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  rf_reg_write,
    output logic [ADDR_WIDTH-1:0] rf_write_register,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  rf_src,
    output logic                  init_done
);

    // One extra bit so NUM_REGS itself is representable in the range check
    localparam int unsigned ADDR_EXT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0]     LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_EXT_WIDTH-1:0] REG_LIMIT = ADDR_EXT_WIDTH'(NUM_REGS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Priority pointer encoding: 0 favours A, 1 favours B
    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_prio;
    logic                  r_rf_reg_write;
    logic [ADDR_WIDTH-1:0] r_rf_write_register;
    logic [DATA_WIDTH-1:0] r_rf_write_data;
    logic                  r_rf_src;
    logic                  r_init_done;

    logic                  w_run;
    logic                  w_a_ready;
    logic                  w_b_ready;
    logic                  w_a_xfer;
    logic                  w_b_xfer;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic                  w_addr_ok;

    // Arbitration: readies depend only on the other requester and the pointer,
    // so at most one of the two transfers can happen in a cycle
    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_a_ready  = w_run && (!b_valid || (r_prio == PRIO_A));
        w_b_ready  = w_run && (!a_valid || (r_prio == PRIO_B));
        w_a_xfer   = a_valid && w_a_ready;
        w_b_xfer   = b_valid && w_b_ready;
        w_xfer     = w_a_xfer || w_b_xfer;
        w_win_addr = w_b_xfer ? b_addr : a_addr;
        w_win_data = w_b_xfer ? b_data : a_data;
        // Register 0 is hardwired and indices past the array are not storage
        w_addr_ok  = (w_win_addr != '0) && ({1'b0, w_win_addr} < REG_LIMIT);
    end

    // Control FSM: clear sweep in INIT, arbitrated writeback in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state             <= ST_INIT;
            r_cnt               <= ADDR_WIDTH'(1);
            r_prio              <= PRIO_A;
            r_rf_reg_write      <= 1'b0;
            r_rf_write_register <= '0;
            r_rf_write_data     <= '0;
            r_rf_src            <= 1'b0;
            r_init_done         <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rf_reg_write      <= 1'b1;
                    r_rf_write_register <= r_cnt;
                    r_rf_write_data     <= '0;
                    r_rf_src            <= 1'b0;
                    if (r_cnt == LAST_IDX) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        r_rf_reg_write      <= w_addr_ok;
                        r_rf_write_register <= w_win_addr;
                        r_rf_write_data     <= w_win_data;
                        r_rf_src            <= w_b_xfer;
                        r_prio              <= w_a_xfer ? PRIO_B : PRIO_A;
                    end else begin
                        r_rf_reg_write <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign a_ready           = w_a_ready;
    assign b_ready           = w_b_ready;
    assign rf_reg_write      = r_rf_reg_write;
    assign rf_write_register = r_rf_write_register;
    assign rf_write_data     = r_rf_write_data;
    assign rf_src            = r_rf_src;
    assign init_done         = r_init_done;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed testbench for regfile_write_ctrl with a shadow register-file model.
module tb_regfile_write_ctrl;

    localparam int unsigned NR = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          rf_reg_write;
    logic [AW-1:0] rf_write_register;
    logic [DW-1:0] rf_write_data;
    logic          rf_src;
    logic          init_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] rf_model [0:63] = '{default: 64'hFFFF_FFFF_FFFF_FFFF};

    regfile_write_ctrl #(
        .NUM_REGS   (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .a_valid           (a_valid),
        .a_addr            (a_addr),
        .a_data            (a_data),
        .a_ready           (a_ready),
        .b_valid           (b_valid),
        .b_addr            (b_addr),
        .b_data            (b_data),
        .b_ready           (b_ready),
        .rf_reg_write      (rf_reg_write),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .rf_src            (rf_src),
        .init_done         (init_done)
    );

    always #5 clk = ~clk;

    // Shadow register file committed on the rising edge, like the real array
    always @(posedge clk) begin
        if (rst === 1'b0 && rf_reg_write === 1'b1)
            rf_model[rf_write_register] <= rf_write_data;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check_eq({nm, "_we"},    64'(rf_reg_write),      64'd0);
        check_eq({nm, "_idx"},   64'(rf_write_register), 64'd0);
        check_eq({nm, "_data"},  rf_write_data,          64'd0);
        check_eq({nm, "_src"},   64'(rf_src),            64'd0);
        check_eq({nm, "_done"},  64'(init_done),         64'd0);
        check_eq({nm, "_ardy"},  64'(a_ready),           64'd0);
        check_eq({nm, "_brdy"},  64'(b_ready),           64'd0);
    endtask

    task automatic sweep_check(input int n, input string nm);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({nm, "_we"},   64'(rf_reg_write),      64'd1);
            check_eq({nm, "_idx"},  64'(rf_write_register), 64'(k));
            check_eq({nm, "_data"}, rf_write_data,          64'd0);
            check_eq({nm, "_src"},  64'(rf_src),            64'd0);
            check_eq({nm, "_done"}, 64'(init_done),         64'(k == NR - 1));
            if (k < NR - 1) begin
                check_eq({nm, "_ardy"}, 64'(a_ready), 64'd0);
                check_eq({nm, "_brdy"}, 64'(b_ready), 64'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] exp_addr [0:7];
        logic [DW-1:0] exp_data [0:7];
        int ai;
        int bi;
        logic acc_a;
        logic acc_b;

        exp_addr = '{6'd1, 6'd11, 6'd2, 6'd12, 6'd3, 6'd13, 6'd4, 6'd14};
        exp_data = '{64'hA0, 64'hB0, 64'hA1, 64'hB1, 64'hA2, 64'hB2, 64'hA3, 64'hB3};

        rst     = 1'b0;
        a_valid = 1'b0;
        a_addr  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_addr  = '0;
        b_data  = '0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 check_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b0;

        // Full clear sweep then idle
        sweep_check(NR - 1, "sweep");
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("idle_we",   64'(rf_reg_write), 64'd0);
            check_eq("idle_done", 64'(init_done),    64'd1);
        end
        for (int i = 1; i < NR; i++)
            check_eq("sweep_clr", rf_model[i], 64'd0);

        // Contention: strict A,B alternation, A first after reset
        ai = 0;
        bi = 0;
        for (int c = 0; c < 8; c++) begin
            a_valid = (ai < 4);
            a_addr  = AW'(1 + ai);
            a_data  = 64'(32'hA0 + ai);
            b_valid = (bi < 4);
            b_addr  = AW'(11 + bi);
            b_data  = 64'(32'hB0 + bi);
            #1;
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            @(posedge clk);
            if (acc_a) ai++;
            if (acc_b) bi++;
            @(negedge clk);
            check_eq("rr_we",   64'(rf_reg_write),      64'd1);
            check_eq("rr_idx",  64'(rf_write_register), 64'(exp_addr[c]));
            check_eq("rr_data", rf_write_data,          exp_data[c]);
            check_eq("rr_src",  64'(rf_src),            64'(c % 2));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rr_idle_we", 64'(rf_reg_write), 64'd0);
        for (int i = 0; i < 8; i++)
            check_eq("rr_commit", rf_model[exp_addr[i]], exp_data[i]);

        // Single A request
        a_valid = 1'b1;
        a_addr  = 6'd5;
        a_data  = 64'h0000_0000_DEAD_BEEF;
        #1 check_eq("a1_ready", 64'(a_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check_eq("a1_we",   64'(rf_reg_write),      64'd1);
        check_eq("a1_idx",  64'(rf_write_register), 64'd5);
        check_eq("a1_data", rf_write_data,          64'h0000_0000_DEAD_BEEF);
        check_eq("a1_src",  64'(rf_src),            64'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("a1_reg5", rf_model[5], 64'h0000_0000_DEAD_BEEF);

        // Dropped writes: A to reg 0, then B to out-of-range index 40
        a_valid = 1'b1;
        a_addr  = 6'd0;
        a_data  = 64'h55;
        #1 check_eq("a0_ready", 64'(a_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check_eq("a0_we", 64'(rf_reg_write), 64'd0);
        b_valid = 1'b1;
        b_addr  = 6'd40;
        b_data  = 64'h66;
        #1 check_eq("b40_ready", 64'(b_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        check_eq("b40_we",  64'(rf_reg_write),      64'd0);
        check_eq("b40_idx", 64'(rf_write_register), 64'd40);
        check_eq("b40_src", 64'(rf_src),            64'd1);
        @(posedge clk);
        @(negedge clk);
        check_eq("reg0_untouched", rf_model[0], 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset with B held, abort mid-sweep, then full sweep and B accept
        rst     = 1'b1;
        b_valid = 1'b1;
        b_addr  = 6'd7;
        b_data  = 64'h77;
        @(negedge clk);
        rst = 1'b0;
        sweep_check(10, "abort");
        #2 rst = 1'b1;
        #1 check_reset_vals("mrst");
        @(negedge clk);
        rst = 1'b0;
        sweep_check(NR - 1, "resweep");
        check_eq("b7_ready", 64'(b_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        check_eq("b7_we",   64'(rf_reg_write),      64'd1);
        check_eq("b7_idx",  64'(rf_write_register), 64'd7);
        check_eq("b7_data", rf_write_data,          64'h77);
        check_eq("b7_src",  64'(rf_src),            64'd1);
        @(posedge clk);
        @(negedge clk);
        check_eq("b7_after_we", 64'(rf_reg_write), 64'd0);
        check_eq("b7_reg7",     rf_model[7],       64'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
